axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read arbiter: s0 (icache) / s1 (dcache) share one AR+R channel.
// Ports: s*_ar*/s*_r* requesters, m_* shared AXI, grant/busy/protocol_err status.
module axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s0_araddr,
  input  logic [7:0]  s0_arlen,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic        s0_rvalid,
  output logic        s0_rlast,
  input  logic        s0_rready,
  input  logic [31:0] s1_araddr,
  input  logic [7:0]  s1_arlen,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic        s1_rvalid,
  output logic        s1_rlast,
  input  logic        s1_rready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready,
  output logic        grant,
  output logic        busy,
  output logic        protocol_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e      state_q, state_d, st;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        perr_q, perr_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] addr_q, addr_d;
  logic        beat_hs;

  assign beat_hs = (state_q == DATA) && m_rvalid && m_rready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    perr_d       = perr_q;
    beat_d       = beat_q;
    len_d        = len_q;
    addr_d       = addr_q;
    unique case (state_q)
      IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          grant_d = (s0_arvalid && s1_arvalid) ? ~last_grant_q
                                               : s1_arvalid;
          addr_d  = grant_d ? s1_araddr : s0_araddr;
          len_d   = grant_d ? s1_arlen : s0_arlen;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (beat_hs) begin
          beat_d = beat_q + 8'd1;
          // rlast must coincide exactly with the beat numbered arlen
          if (m_rlast != (beat_q == len_q)) perr_d = 1'b1;
          if (m_rlast) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      perr_q       <= 1'b0;
      beat_q       <= '0;
      len_q        <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      perr_q       <= perr_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
    end
  end

  // Reset silences the channels in the same cycle so no beat leaks mid-abort
  assign st = rst ? IDLE : state_q;

  always_comb begin
    s0_arready   = 1'b0;
    s1_arready   = 1'b0;
    s0_rdata     = '0;
    s0_rvalid    = 1'b0;
    s0_rlast     = 1'b0;
    s1_rdata     = '0;
    s1_rvalid    = 1'b0;
    s1_rlast     = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    m_araddr     = addr_q;
    m_arlen      = len_q;
    grant        = grant_q;
    busy         = (st != IDLE);
    protocol_err = perr_q;
    unique case (st)
      ADDR: begin
        m_arvalid  = 1'b1;
        s0_arready = ~grant_q & m_arready;
        s1_arready = grant_q & m_arready;
      end
      DATA: begin
        m_rready = grant_q ? s1_rready : s0_rready;
        if (grant_q) begin
          s1_rdata  = m_rdata;
          s1_rvalid = m_rvalid;
          s1_rlast  = m_rlast;
        end else begin
          s0_rdata  = m_rdata;
          s0_rvalid = m_rvalid;
          s0_rlast  = m_rlast;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed requests, scoreboard queues,
// negedge monitor comparing AR grants and forwarded R beats.
module tb_axi_rd_arbiter;

  logic        clk, rst;
  logic [31:0] s0_araddr, s1_araddr;
  logic [7:0]  s0_arlen, s1_arlen;
  logic        s0_arvalid, s1_arvalid;
  logic        s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_rvalid, s1_rvalid;
  logic        s0_rlast, s1_rlast;
  logic        s0_rready, s1_rready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_rlast, m_rready;
  logic        grant, busy, protocol_err;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rvalid(s0_rvalid),
    .s0_rlast(s0_rlast), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rvalid(s1_rvalid),
    .s1_rlast(s1_rlast), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .m_rready(m_rready),
    .grant(grant), .busy(busy), .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         exp_ar[$];
  logic [32:0] exp_r0[$];
  logic [32:0] exp_r1[$];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    ar_t         e;
    logic [32:0] r;
    if (m_arvalid && m_arready) begin
      if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
      else begin
        e = exp_ar.pop_front();
        chk("ar_grant", {31'd0, grant}, e.port);
        chk("ar_addr", m_araddr, e.addr);
        chk("ar_len", {24'd0, m_arlen}, {24'd0, e.len});
        chk("ar_ready", {30'd0, s1_arready, s0_arready},
            (e.port == 1) ? 32'd2 : 32'd1);
      end
    end
    if (s0_rvalid && s0_rready) begin
      if (exp_r0.size() == 0) chk("r0_unexpected", 1, 0);
      else begin
        r = exp_r0.pop_front();
        chk("r0_data", s0_rdata, r[31:0]);
        chk("r0_last", {31'd0, s0_rlast}, {31'd0, r[32]});
      end
    end
    if (s1_rvalid && s1_rready) begin
      if (exp_r1.size() == 0) chk("r1_unexpected", 1, 0);
      else begin
        r = exp_r1.pop_front();
        chk("r1_data", s1_rdata, r[31:0]);
        chk("r1_last", {31'd0, s1_rlast}, {31'd0, r[32]});
      end
    end
  end

  task automatic chk_reset_outs();
    chk("rst_busy_grant", {30'd0, busy, grant}, 0);
    chk("rst_m_ctl", {30'd0, m_arvalid, m_rready}, 0);
    chk("rst_m_addr", m_araddr, 0);
    chk("rst_m_len", {24'd0, m_arlen}, 0);
    chk("rst_s_ctl", {26'd0, s0_arready, s1_arready, s0_rvalid,
                      s1_rvalid, s0_rlast, s1_rlast}, 0);
    chk("rst_rdata", s0_rdata | s1_rdata, 0);
    chk("rst_perr", {31'd0, protocol_err}, 0);
  endtask

  task automatic ar_phase(input int p, input int dly, input bit keep);
    ar_t e;
    int  to;
    e.port = p;
    e.addr = (p == 1) ? s1_araddr : s0_araddr;
    e.len  = (p == 1) ? s1_arlen : s0_arlen;
    exp_ar.push_back(e);
    to = 0;
    @(negedge clk);
    while (!m_arvalid && to < 50) begin
      @(negedge clk);
      to++;
    end
    if (to >= 50) chk("ar_timeout", 1, 0);
    repeat (dly + 1) @(posedge clk);
    #1 m_arready = 1'b1;
    @(posedge clk);
    #1 m_arready = 1'b0;
    if (!keep) begin
      if (p == 1) s1_arvalid = 1'b0;
      else s0_arvalid = 1'b0;
    end
  endtask

  task automatic r_phase(input int p, input int nb, input int last_at,
                         input logic [31:0] base, input bit tog);
    bit hs;
    int to;
    for (int i = 0; i < nb; i++) begin
      if (p == 1) exp_r1.push_back({i == last_at, base + i});
      else exp_r0.push_back({i == last_at, base + i});
      m_rvalid = 1'b1;
      m_rdata  = base + i;
      m_rlast  = (i == last_at);
      hs = 1'b0;
      to = 0;
      while (!hs && to < 50) begin
        @(negedge clk);
        hs = m_rready;
        if (tog) chk("rready_mirror", {31'd0, m_rready}, {31'd0, s1_rready});
        @(posedge clk);
        #1;
        if (tog) s1_rready = ~s1_rready;
        to++;
      end
      if (!hs) chk("r_timeout", 1, 0);
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s1_rready = 1'b1;
    if (last_at >= 0) begin
      @(negedge clk);
      chk("idle_gap", {30'd0, busy, m_arvalid}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s0_araddr = '0; s1_araddr = '0;
    s0_arlen = '0;  s1_arlen = '0;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    s0_rready = 1'b1;  s1_rready = 1'b1;
    m_arready = 1'b0;  m_rvalid = 1'b0;
    m_rlast = 1'b0;    m_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs();

    // tie after reset: 0, then 1, then 0
    @(posedge clk);
    #1;
    s0_araddr = 32'h0000_1000; s0_arlen = 8'd1; s0_arvalid = 1'b1;
    s1_araddr = 32'h0000_2000; s1_arlen = 8'd1; s1_arvalid = 1'b1;
    ar_phase(0, 0, 1);
    r_phase(0, 2, 1, 32'h1100_0000, 0);
    ar_phase(1, 0, 1);
    r_phase(1, 2, 1, 32'h1200_0000, 0);
    ar_phase(0, 0, 1);
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    r_phase(0, 2, 1, 32'h1300_0000, 0);

    // single s0 burst of 8, checks one-cycle AR latency
    @(posedge clk);
    #1;
    s0_araddr = 32'h1FC0_0000; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    @(negedge clk);
    chk("lat_same_cycle", {31'd0, m_arvalid}, 0);
    @(negedge clk);
    chk("lat_next_cycle", {31'd0, m_arvalid}, 1);
    ar_phase(0, 2, 0);
    r_phase(0, 8, 7, 32'hC0DE_0000, 0);
    chk("single_perr", {31'd0, protocol_err}, 0);

    // s1 backpressure, arlen 3
    s1_araddr = 32'h0000_4000; s1_arlen = 8'd3; s1_arvalid = 1'b1;
    ar_phase(1, 0, 0);
    r_phase(1, 4, 3, 32'hDA7A_0000, 1);

    // early rlast on beat 5 of 8
    s0_araddr = 32'h0000_8000; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    ar_phase(0, 1, 0);
    r_phase(0, 5, 4, 32'hE000_0000, 0);
    chk("perr_set", {31'd0, protocol_err}, 1);
    s0_araddr = 32'h0000_9000; s0_arlen = 8'd1; s0_arvalid = 1'b1;
    ar_phase(0, 0, 0);
    r_phase(0, 2, 1, 32'hE100_0000, 0);
    chk("perr_sticky", {31'd0, protocol_err}, 1);

    // reset on beat 3 of 8
    s0_araddr = 32'h8000_0000; s0_arlen = 8'd7; s0_arvalid = 1'b1;
    ar_phase(0, 0, 0);
    r_phase(0, 2, -1, 32'hF000_0000, 0);
    rst = 1'b1;
    m_rvalid = 1'b1;
    m_rdata = 32'hF000_0002;
    @(negedge clk);
    chk("rst_no_fwd", {30'd0, s0_rvalid, m_rready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_rvalid = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    s0_araddr = 32'h0000_A000; s0_arlen = 8'd3; s0_arvalid = 1'b1;
    ar_phase(0, 1, 0);
    r_phase(0, 4, 3, 32'hA500_0000, 0);
    chk("fresh_perr", {31'd0, protocol_err}, 0);

    // continuous requests alternate, last grant was port 0
    s0_araddr = 32'h0000_B000; s0_arlen = 8'd0; s0_arvalid = 1'b1;
    s1_araddr = 32'h0000_C000; s1_arlen = 8'd0; s1_arvalid = 1'b1;
    ar_phase(1, 0, 1);
    r_phase(1, 1, 0, 32'h5100_0000, 0);
    ar_phase(0, 0, 1);
    r_phase(0, 1, 0, 32'h5000_0000, 0);
    ar_phase(1, 0, 1);
    r_phase(1, 1, 0, 32'h5101_0000, 0);
    ar_phase(0, 0, 1);
    s0_arvalid = 1'b0;
    s1_arvalid = 1'b0;
    r_phase(0, 1, 0, 32'h5001_0000, 0);

    repeat (3) @(negedge clk);
    chk("queues_drained", exp_ar.size() + exp_r0.size() + exp_r1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
